shift_reg_tx: RTL and testbench
===============================

// Module: shift_reg_tx
// PURPOSE
//   Parallel-in/serial-out shift register: the transmit end of the lab serial link.
//   Captures a WIDTH-bit word on start and shifts it out MSB first, one bit per DIV clocks.
//   Bit order matches the LSB-entry serial-in register on the receiving side:
//   after WIDTH strobed shifts the receiver holds the word unchanged.
//   Sits between board switches/control and the serial line or the receiver board.
// PARAMETERS
//   WIDTH  10  data word width in bits (>=2)
//   DIV    1   clock cycles per transmitted bit (>=1)
// PORTS
//   clk      in   1      system clock, rising edge
//   rst      in   1      asynchronous reset, active low
//   start    in   1      request a transmission; sampled only in IDLE
//   data_in  in   WIDTH  word to send; captured on the accepting edge
//   ser_out  out  1      serial data, MSB first
//   bit_stb  out  1      1-cycle pulse in the last cycle of each bit period (receiver shift enable)
//   busy     out  1      high while a frame is being shifted
//   done     out  1      1-cycle pulse after the final bit period
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE; ser_out=0, bit_stb=0, busy=0, done=0.
//     Shift register, bit counter and divider are cleared. A frame in flight is abandoned
//     and produces no done.
//   - FSM states: IDLE, SHIFT.
//   - IDLE: ser_out=0, busy=0. If start=1 at a rising edge: load shreg<=data_in,
//     bit_cnt<=0, div_cnt<=0, go to SHIFT.
//     Next cycle: busy=1, ser_out=data_in[WIDTH-1] (latency 1 clock).
//   - SHIFT: ser_out=shreg[MSB]. div_cnt counts 0..DIV-1. When div_cnt==DIV-1: bit_stb=1.
//     On that edge shreg shifts left (zero fill), bit_cnt increments, div_cnt wraps to 0.
//   - After the strobe of the last bit (bit_cnt==NBITS-1): go to IDLE.
//     The next cycle has busy=0, done=1, ser_out=0.
//   - NBITS = WIDTH, or WIDTH+1 with parity (see CONFIGURATION).
//     Frame length = NBITS*DIV cycles of busy=1.
//   - start while busy=1: ignored; data_in is not sampled.
//   - start in the done cycle: accepted (state is IDLE), giving back-to-back frames with a
//     single idle cycle between them.
//   - Counter widths: div_cnt is $clog2(DIV) bits (min 1); bit_cnt is $clog2(NBITS+1) bits.
//     Both are unsigned and never exceed their terminal value.
//   - DIV=1: bit_stb is high on every SHIFT cycle and ser_out changes every clock.
//   - data_in changes after capture have no effect on the frame.
// CONFIGURATION
//   SHIFT_TX_PARITY_EN defined:
//     - An even-parity bit, the XOR of the captured word (computed at load), is sent after
//       the LSB as bit NBITS-1, with its own full DIV period and bit_stb.
//     - Frame length is (WIDTH+1)*DIV.
//   Not defined:
//     - Exactly WIDTH bits are sent; no parity logic is present.
// TESTING
//   (WIDTH=10, DIV=1 unless noted)
//   1. Reset then start=1 with data_in=10'b1011001110.
//      -> ser_out=1,0,1,1,0,0,1,1,1,0 on cycles 1..10 with busy=1; cycle 11 busy=0, done=1.
//   2. Loopback: 10-bit LSB-entry register shifting ser_out on bit_stb, send 10'h2A5.
//      -> receiver holds 10'h2A5 when done=1.
//   3. DIV=4, data_in=10'h3FF.
//      -> each bit held 4 cycles; bit_stb every 4th cycle (10 pulses); busy for 40 cycles.
//   4. Pulse start with 10'h155 mid-frame while sending 10'h0F0.
//      -> output is 10'h0F0 only; a single done pulse.
//   5. Drop rst at bit 5 of a frame.
//      -> same cycle: ser_out=0, busy=0, no done. A start after release sends a full new frame.
//   6. With SHIFT_TX_PARITY_EN, send 10'b0000000111.
//      -> 11 bits; 11th bit=1; busy for 11 cycles. Same test with 10'h003 gives 11th bit=0.

Source files
------------

// File: rtl/shift_reg_tx.sv
// shift_reg_tx: transmit end of the lab serial link.
//   Captures a WIDTH-bit word when start_i is seen in IDLE and shifts it out MSB
//   first, one bit every DIV clocks. The bit order suits an LSB-entry serial-in
//   register on the receiving side, which holds the word unchanged after
//   all the strobed shifts.
//
// Optional feature macro: SHIFT_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the captured word) is appended after
//   the LSB as an extra bit period, so each frame carries WIDTH+1 bits.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous reset, active low
//   start_i    transmission request, sampled only in IDLE
//   data_in_i  word to send, captured on the accepting edge
//   ser_out_o  serial data, MSB first (0 when idle)
//   bit_stb_o  1-cycle pulse in the last cycle of each bit period
//   busy_o     high while a frame is being shifted
//   done_o     1-cycle pulse in the cycle after the final bit period
module shift_reg_tx #(
  parameter int WIDTH = 10,
  parameter int DIV   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic             ser_out_o,
  output logic             bit_stb_o,
  output logic             busy_o,
  output logic             done_o
);

`ifdef SHIFT_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] load_word;
  logic             bit_stb;

  // The parity bit is computed from the word as captured and sits in the LSB
  // slot, so it leaves the line after all data bits.
`ifdef SHIFT_TX_PARITY_EN
  assign load_word = {data_in_i, ^data_in_i};
`else
  assign load_word = data_in_i;
`endif

  // State and datapath registers; reset abandons any frame in flight, and
  // clearing done_q here guarantees an aborted frame never reports done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. The strobe marks the final cycle of a bit period; on
  // that edge the register shifts (zero fill) and the bit counter advances.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    done_d    = 1'b0;
    bit_stb   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shreg_d   = load_word;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          bit_stb   = 1'b1;
          shreg_d   = {shreg_q[NBITS-2:0], 1'b0};
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q == SHIFT);
  assign ser_out_o = (state_q == SHIFT) & shreg_q[NBITS-1];
  assign bit_stb_o = bit_stb;
  assign done_o    = done_q;

endmodule

// File: tb/tb_shift_reg_tx.sv
// tb_shift_reg_tx: directed self-checking bench for shift_reg_tx.
//   Two instances share clock and reset: dut1 runs with DIV=1, dut4 with DIV=4.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Honours SHIFT_TX_PARITY_EN so frame length and bit pattern follow the build.
module tb_shift_reg_tx;

`ifdef SHIFT_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start4;
  logic [9:0] data1, data4;
  logic       ser1, stb1, busy1, done1;
  logic       ser4, stb4, busy4, done4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_reg_tx #(.WIDTH(10), .DIV(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .data_in_i(data1),
    .ser_out_o(ser1), .bit_stb_o(stb1), .busy_o(busy1), .done_o(done1)
  );

  shift_reg_tx #(.WIDTH(10), .DIV(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .data_in_i(data4),
    .ser_out_o(ser4), .bit_stb_o(stb4), .busy_o(busy4), .done_o(done4)
  );

  // Expected on-line bit sequence, index NB-1 leaves first.
  function automatic logic [NB-1:0] frameBits(input logic [9:0] d);
`ifdef SHIFT_TX_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0; data1 = '0; data4 = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ser1, stb1, busy1, done1} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_dut1 got %b want 0000", {ser1, stb1, busy1, done1});
    end
    checks++;
    if ({ser4, stb4, busy4, done4} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_dut4 got %b want 0000", {ser4, stb4, busy4, done4});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ser1, busy1, done1} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got %b want 000", {ser1, busy1, done1});
    end
  endtask

  // Walks one dut1 frame from its first busy cycle through the done cycle,
  // with a model LSB-entry receiver that shifts on each strobe. Optionally
  // pulses start and changes data_in mid-frame, which must have no effect.
  task automatic walkFrame1(input logic [9:0] d, input bit pulseMid, input string name);
    logic [NB-1:0] exp;
    logic [NB-1:0] rx;
    exp = frameBits(d);
    rx  = '0;
    for (int k = 0; k < NB; k++) begin
      if (k > 0) @(negedge clk);
      if (pulseMid && k == 4) begin
        start1 = 1'b1;
        data1  = 10'h155;
      end else begin
        start1 = 1'b0;
      end
      checks++;
      if ({busy1, ser1, stb1, done1} !== {1'b1, exp[NB-1-k], 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL %s_bit%0d got busy/ser/stb/done=%b want %b", name, k,
                 {busy1, ser1, stb1, done1}, {1'b1, exp[NB-1-k], 1'b1, 1'b0});
      end
      if (stb1) rx = {rx[NB-2:0], ser1};
    end
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if ({busy1, ser1, stb1, done1} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL %s_done got busy/ser/stb/done=%b want 0001", name,
               {busy1, ser1, stb1, done1});
    end
    checks++;
    if (rx !== exp) begin
      errors++;
      $display("[TB] FAIL %s_loopback got %h want %h", name, rx, exp);
    end
  endtask

  task automatic test_basic(input logic [9:0] d, input string name);
    @(negedge clk);
    start1 = 1'b1;
    data1  = d;
    @(negedge clk);
    start1 = 1'b0;
    data1  = ~d;
    walkFrame1(d, 1'b0, name);
    @(negedge clk);
    checks++;
    if ({busy1, done1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL %s_after got busy/done=%b want 00", name, {busy1, done1});
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    @(negedge clk);
    start1 = 1'b1;
    data1  = 10'h0F0;
    @(negedge clk);
    walkFrame1(10'h0F0, 1'b1, "midstart");
    dones = 1;
    for (int c = 0; c < NB + 3; c++) begin
      @(negedge clk);
      if (done1) dones++;
      checks++;
      if (busy1 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midstart_no_refire cycle %0d got busy=%b want 0", c, busy1);
      end
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("[TB] FAIL midstart_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start1 = 1'b1;
    data1  = 10'h2A5;
    @(negedge clk);
    walkFrame1(10'h2A5, 1'b0, "b2b_a");
    start1 = 1'b1;
    data1  = 10'h15A;
    @(negedge clk);
    walkFrame1(10'h15A, 1'b0, "b2b_b");
    @(negedge clk);
  endtask

  task automatic test_div4(input logic [9:0] d, input string name);
    logic [NB-1:0] exp;
    int pulses;
    exp    = frameBits(d);
    pulses = 0;
    @(negedge clk);
    start4 = 1'b1;
    data4  = d;
    @(negedge clk);
    start4 = 1'b0;
    data4  = ~d;
    for (int c = 0; c < NB * 4; c++) begin
      if (c > 0) @(negedge clk);
      if (stb4) pulses++;
      checks++;
      if ({busy4, ser4, stb4, done4} !== {1'b1, exp[NB-1-c/4], (c % 4 == 3), 1'b0}) begin
        errors++;
        $display("[TB] FAIL %s_cycle%0d got busy/ser/stb/done=%b want %b", name, c,
                 {busy4, ser4, stb4, done4}, {1'b1, exp[NB-1-c/4], (c % 4 == 3), 1'b0});
      end
    end
    @(negedge clk);
    checks++;
    if ({busy4, ser4, stb4, done4} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL %s_done got %b want 0001", name, {busy4, ser4, stb4, done4});
    end
    checks++;
    if (pulses !== NB) begin
      errors++;
      $display("[TB] FAIL %s_strobes got %0d want %0d", name, pulses, NB);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start1 = 1'b1;
    data1  = 10'h3C3;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_busy_before got %b want 1", busy1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ser1, busy1, done1, stb1} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rstmid_async got ser/busy/done/stb=%b want 0000",
               {ser1, busy1, done1, stb1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({busy1, done1} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL rstmid_no_done cycle %0d got busy/done=%b want 00", c,
                 {busy1, done1});
      end
    end
    test_basic(10'h1E1, "rstmid_new");
  endtask

  initial begin
    test_reset();
    test_basic(10'b1011001110, "basic");
    test_basic(10'h2A5, "loop2a5");
    test_basic(10'b0000000111, "par007");
    test_basic(10'h003, "par003");
    test_start_ignored();
    test_back_to_back();
    test_div4(10'h3FF, "div4_3ff");
    test_div4(10'h2A5, "div4_2a5");
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
